// File: rtl/fetch_stage.sv
// Instruction fetch sequencer: req/ack fetch into a one-deep holding register, one idle cycle after reset.
// Zero-wait memory gives one instruction per 2 cycles; decode stalls via if_ready hold the word and the PC.
module fetch_stage #(
   parameter int         ADDR_W   = 16,
   parameter int         INST_W   = 16,
   parameter logic [3:0] HALT_OPC = 4'hF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic [ADDR_W-1:0] pc_next,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [INST_W-1:0] if_inst,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus2,
   output logic              halted
);

   typedef enum logic [1:0] {ST_START, ST_REQ, ST_HOLD, ST_HALT} state_e;

   state_e            state_q, state_d;
   logic              redir_pend_q, redir_pend_d;
   logic [ADDR_W-1:0] redir_tgt_q, redir_tgt_d;
   logic [INST_W-1:0] if_inst_q, if_inst_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [ADDR_W-1:0] if_pc_plus2_q, if_pc_plus2_d;
   logic [ADDR_W-1:0] pc_plus2;

   assign pc_plus2    = pc_cur + ADDR_W'(2);
   assign imem_addr   = pc_cur;
   assign if_inst     = if_inst_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus2 = if_pc_plus2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_START;
         redir_pend_q  <= 1'b0;
         redir_tgt_q   <= '0;
         if_inst_q     <= '0;
         if_pc_q       <= '0;
         if_pc_plus2_q <= '0;
      end else begin
         state_q       <= state_d;
         redir_pend_q  <= redir_pend_d;
         redir_tgt_q   <= redir_tgt_d;
         if_inst_q     <= if_inst_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus2_q <= if_pc_plus2_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      redir_pend_d  = redir_pend_q;
      redir_tgt_d   = redir_tgt_q;
      if_inst_d     = if_inst_q;
      if_pc_d       = if_pc_q;
      if_pc_plus2_d = if_pc_plus2_q;
      pc_next       = pc_cur;
      imem_req      = 1'b0;
      if_valid      = 1'b0;
      halted        = 1'b0;
      case (state_q)
         ST_START: state_d = ST_REQ;
         ST_REQ: begin
            imem_req = 1'b1;
            if (!imem_ack) begin
               if (br_taken) begin
                  redir_tgt_d  = br_target;
                  redir_pend_d = 1'b1;
               end
            end else if (redir_pend_q || br_taken) begin
               // Wrong-path word: drop it and re-request at the redirect address.
               pc_next      = br_taken ? br_target : redir_tgt_q;
               redir_pend_d = 1'b0;
            end else begin
               if_inst_d     = imem_rdata;
               if_pc_d       = pc_cur;
               if_pc_plus2_d = pc_plus2;
               pc_next       = pc_plus2;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if_valid = ~br_taken;
            if (br_taken) begin
               pc_next = br_target;
               state_d = ST_REQ;
            end else if (if_ready) begin
               state_d = (if_inst_q[INST_W-1 -: 4] == HALT_OPC) ? ST_HALT : ST_REQ;
            end
         end
         ST_HALT: halted = 1'b1;
         default: state_d = ST_START;
      endcase
   end

endmodule
